wb_slave_mux: RTL and testbench

Parametrised Wishbone classic interconnect that replaces the fixed 4-way combinational strobe decode behind epb_wb_bridge. It connects one master to NUM_SLAVES slaves and decodes on the top SEL_BITS address bits. Decode and response are registered, which improves timing on the CPLD. Adds an unmapped-slot error, a per-transaction ack timeout, and sticky error status, so that a dead or missing slave cannot hang the EPB.

---
 rtl/wb_slave_mux.sv | 195 +++++++++++++++++++
 tb/tb_wb_slave_mux.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mux.sv
// Wishbone classic 1-master to NUM_SLAVES-slave interconnect with registered decode and response.
// Latency: strobe one cycle after the request; ack/err one cycle after the slave ack or decision.
// Backpressure: accepts a request only in IDLE; a missing or dead slave ends in an error response.
module wb_slave_mux #(
  parameter int DW         = 8,
  parameter int AW         = 5,
  parameter int SEL_BITS   = 2,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  input  logic                     m_we_i,
  input  logic                     m_sel_i,
  input  logic [AW-1:0]            m_adr_i,
  input  logic [DW-1:0]            m_dat_i,
  output logic [DW-1:0]            m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic                     s_sel_o,
  output logic [AW-SEL_BITS-1:0]   s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  input  logic                     err_clr_i,
  output logic [7:0]               err_cnt_o,
  output logic [AW-1:0]            err_adr_o
);

  localparam int LAW = AW - SEL_BITS;
  // One bit wider than a slot so that NUM_SLAVES == 2^SEL_BITS is representable.
  localparam logic [SEL_BITS:0] NUM_MAPPED = (SEL_BITS + 1)'(NUM_SLAVES);
  localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic          sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;

  state_t                state;
  req_t                  req_q;
  logic [SEL_BITS-1:0]   slot_q;
  logic [7:0]            tmo_cnt;

  logic [SEL_BITS-1:0]   req_slot;
  logic                  req_go;
  logic                  req_mapped;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic [DW-1:0]         slot_dat;
  logic                  slot_ack;
  logic                  err_raise;
  logic [AW-1:0]         err_raise_adr;

  assign req_slot   = m_adr_i[AW-1 -: SEL_BITS];
  assign req_go     = m_cyc_i & m_stb_i;
  assign req_mapped = ({1'b0, req_slot} < NUM_MAPPED);

  // Shared slave-side signals are driven straight from the latched request.
  assign s_we_o  = req_q.we;
  assign s_sel_o = req_q.sel;
  assign s_adr_o = req_q.adr[LAW-1:0];
  assign s_dat_o = req_q.dat;

  // Decode the incoming slot to a one-hot strobe pattern.
  always_comb begin
    req_onehot = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot[k] = (req_slot == SEL_BITS'(k));
    end
  end

  // Pick the selected slave's data and ack; other slaves' acks never reach the FSM.
  always_comb begin
    slot_dat = '0;
    slot_ack = 1'b0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (slot_q == SEL_BITS'(k)) begin
        slot_dat = s_dat_i[k*DW +: DW];
        slot_ack = s_ack_i[k];
      end
    end
  end

  // An error response is being decided this cycle: unmapped request or ack timeout.
  always_comb begin
    err_raise     = 1'b0;
    err_raise_adr = req_q.adr;
    if (state == IDLE && req_go && !req_mapped) begin
      err_raise     = 1'b1;
      err_raise_adr = m_adr_i;
    end else if (state == ACTIVE && m_cyc_i && !slot_ack && tmo_cnt == TO_LAST) begin
      err_raise = 1'b1;
    end
  end

  // Transaction FSM with registered strobes and master response.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state   <= IDLE;
      req_q   <= '0;
      slot_q  <= '0;
      tmo_cnt <= '0;
      s_cyc_o <= '0;
      s_stb_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_go) begin
            req_q.we  <= m_we_i;
            req_q.sel <= m_sel_i;
            req_q.adr <= m_adr_i;
            req_q.dat <= m_dat_i;
            slot_q    <= req_slot;
            tmo_cnt   <= '0;
            if (req_mapped) begin
              state   <= ACTIVE;
              s_cyc_o <= req_onehot;
              s_stb_o <= req_onehot;
            end else begin
              state   <= RESP;
              m_err_o <= 1'b1;
              m_dat_o <= '1;
            end
          end
        end
        ACTIVE: begin
          if (!m_cyc_i) begin
            // Master abandoned the cycle: drop the strobe silently.
            state   <= IDLE;
            s_cyc_o <= '0;
            s_stb_o <= '0;
          end else if (slot_ack) begin
            // Ack takes priority over a timeout landing in the same cycle.
            state   <= RESP;
            s_cyc_o <= '0;
            s_stb_o <= '0;
            m_ack_o <= 1'b1;
            m_dat_o <= slot_dat;
          end else if (tmo_cnt == TO_LAST) begin
            state   <= RESP;
            s_cyc_o <= '0;
            s_stb_o <= '0;
            m_err_o <= 1'b1;
            m_dat_o <= '1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error status; a clear never erases the error that is being reported right now.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      err_cnt_o <= '0;
      err_adr_o <= '0;
    end else if (err_raise) begin
      err_adr_o <= err_raise_adr;
      if (err_clr_i) begin
        err_cnt_o <= 8'd1;
      end else if (err_cnt_o != 8'hFF) begin
        err_cnt_o <= err_cnt_o + 8'd1;
      end
    end else if (err_clr_i) begin
      if (m_err_o) begin
        err_cnt_o <= 8'd1;
      end else begin
        err_cnt_o <= '0;
        err_adr_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_mux.sv
// Self-checking bench for wb_slave_mux: 3 slaves on a 4-slot map, ack timeout of 4 cycles.
// Inputs are driven and outputs sampled on the falling edge; cycle 0 is the request cycle.
// A behavioural model predicts response kind, timing, data and the error status.
module tb_wb_slave_mux;

  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int SB   = 2;
  localparam int NSLV = 3;
  localparam int TMO  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_cyc, m_stb, m_we, m_sel;
  logic [AW-1:0]    m_adr;
  logic [DW-1:0]    m_dat;
  logic [DW-1:0]    m_dat_o;
  logic             m_ack, m_err;
  logic [NSLV-1:0]  s_cyc, s_stb;
  logic             s_we, s_sel;
  logic [AW-SB-1:0] s_adr;
  logic [DW-1:0]    s_dat_o;
  logic [NSLV*DW-1:0] s_dat_i;
  logic [NSLV-1:0]  s_ack;
  logic             err_clr;
  logic [7:0]       err_cnt;
  logic [AW-1:0]    err_adr;

  int passed = 0;
  int total  = 0;

  // Reference status model
  int         mdl_cnt = 0;
  logic [4:0] mdl_adr = '0;
  logic [7:0] mdl_dat = '0;

  wb_slave_mux #(.DW(DW), .AW(AW), .SEL_BITS(SB), .NUM_SLAVES(NSLV), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
    .err_clr_i(err_clr), .err_cnt_o(err_cnt), .err_adr_o(err_adr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  // Behavioural prediction of one transaction from the address map and slave ack delay.
  function automatic void predict(input logic [4:0] adr, input int ack_dly, input logic [7:0] rdat,
                                  input logic clr, output logic e_ack, output logic e_err,
                                  output int e_cyc, output int e_stb, output logic [7:0] e_dat);
    int slot;
    slot  = int'(adr) / 8;
    e_ack = 1'b0;
    e_err = 1'b0;
    if (slot >= NSLV) begin
      e_err = 1'b1; e_cyc = 1; e_stb = 0; e_dat = 8'hFF;
    end else if (ack_dly >= 0 && ack_dly < TMO) begin
      e_ack = 1'b1; e_cyc = ack_dly + 2; e_stb = ack_dly + 1; e_dat = rdat;
    end else begin
      e_err = 1'b1; e_cyc = TMO + 1; e_stb = TMO; e_dat = 8'hFF;
    end
    if (clr) begin
      mdl_cnt = 0;
      mdl_adr = '0;
    end
    if (e_err) begin
      if (mdl_cnt < 255) mdl_cnt++;
      mdl_adr = adr;
    end
    mdl_dat = e_dat;
  endfunction

  // Drive one master transaction plus the slave side, and record what the DUT did.
  task automatic run_txn(input logic [4:0] adr, input logic we, input logic sel, input logic [7:0] wdat,
                         input int ack_dly, input logic [7:0] rdat, input int abort_at, input logic clr_at_req,
                         output int resp_cyc, output int nresp, output logic got_ack, output logic got_err,
                         output logic [7:0] dat_seen, output int stb_cycles, output logic bad_stb,
                         output logic bad_shared, output logic [7:0] cnt_seen, output logic [4:0] eadr_seen);
    int slot;
    slot = int'(adr) / 8;
    resp_cyc = -1; nresp = 0; got_ack = 1'b0; got_err = 1'b0; dat_seen = '0;
    stb_cycles = 0; bad_stb = 1'b0; bad_shared = 1'b0; cnt_seen = '0; eadr_seen = '0;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat = wdat;
    err_clr = clr_at_req;
    s_dat_i = 24'($urandom);
    if (slot < NSLV) s_dat_i[slot*DW +: DW] = rdat;
    for (int t = 1; t <= 24; t++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (m_ack === 1'b1 || m_err === 1'b1) begin
        nresp++;
        if (resp_cyc < 0) begin
          resp_cyc = t; got_ack = m_ack; got_err = m_err; dat_seen = m_dat_o;
          cnt_seen = err_cnt; eadr_seen = err_adr;
        end
      end
      if ($isunknown(s_stb) || s_stb !== s_cyc) bad_stb = 1'b1;
      for (int k = 0; k < NSLV; k++) begin
        if (s_stb[k] === 1'b1) begin
          if (k != slot || resp_cyc >= 0 || (abort_at >= 0 && t > abort_at)) bad_stb = 1'b1;
          else stb_cycles++;
        end
      end
      if (s_stb != '0 && (s_adr !== adr[2:0] || s_we !== we || s_sel !== sel || s_dat_o !== wdat))
        bad_shared = 1'b1;
      // Non-selected slaves ack at random; only the selected slave follows ack_dly.
      s_ack = 3'($urandom);
      if (slot < NSLV) s_ack[slot] = 1'b0;
      if (resp_cyc >= 0 || t == abort_at) begin
        m_cyc = 1'b0; m_stb = 1'b0;
      end else if (ack_dly >= 0 && t == 1 + ack_dly && slot < NSLV) begin
        s_ack[slot] = 1'b1;
      end
      if (resp_cyc >= 0 && t >= resp_cyc + 2) break;
      if (abort_at >= 0 && t >= abort_at + 6) break;
    end
    s_ack = '0; m_cyc = 1'b0; m_stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] v;
    rst_n = 1'b0; m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 0; m_adr = '0; m_dat = '0;
    s_dat_i = '0; s_ack = '0; err_clr = 0;
    repeat (2) @(negedge clk);
    v = {m_ack, m_err, m_dat_o, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, err_cnt, err_adr};
    total++; if (v !== '0) $display("FAIL reset_outputs: got %h, need 0", v); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    run_txn(5'h12, 1'b0, 1'b1, 8'h5A, 3, 8'hA5, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h12, 3, 8'hA5, 1'b0, ea, ee, ec, es, ed);
    total++; if (ga !== ea || ge !== ee) $display("FAIL read_kind: ack=%b err=%b, need %b %b", ga, ge, ea, ee); else passed++;
    total++; if (rc != ec || nr != 1) $display("FAIL read_timing: cyc=%0d n=%0d, need cyc=%0d n=1", rc, nr, ec); else passed++;
    total++; if (ds !== ed) $display("FAIL read_data: got %h, need %h", ds, ed); else passed++;
    total++; if (sc != es || bs !== 1'b0 || bh !== 1'b0) $display("FAIL read_strobe: cycles=%0d bad=%b shared=%b, need %0d 0 0", sc, bs, bh, es); else passed++;
  endtask

  task automatic test_write();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    run_txn(5'h08, 1'b1, 1'b1, 8'h3C, 0, 8'h77, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h08, 0, 8'h77, 1'b0, ea, ee, ec, es, ed);
    total++; if (ga !== ea || ge !== ee || rc != ec) $display("FAIL write_resp: ack=%b err=%b cyc=%0d, need %b %b %0d", ga, ge, rc, ea, ee, ec); else passed++;
    total++; if (sc != es || bs !== 1'b0 || bh !== 1'b0) $display("FAIL write_strobe: cycles=%0d bad=%b shared=%b, need %0d 0 0", sc, bs, bh, es); else passed++;
  endtask

  task automatic test_timeout();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    run_txn(5'h03, 1'b0, 1'b0, 8'h00, -1, 8'h11, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h03, -1, 8'h11, 1'b0, ea, ee, ec, es, ed);
    total++; if (ga !== ea || ge !== ee || rc != ec || nr != 1) $display("FAIL tmo_resp: ack=%b err=%b cyc=%0d n=%0d, need %b %b %0d 1", ga, ge, rc, nr, ea, ee, ec); else passed++;
    total++; if (sc != es || bs !== 1'b0) $display("FAIL tmo_strobe: cycles=%0d bad=%b, need %0d 0", sc, bs, es); else passed++;
    total++; if (ds !== ed) $display("FAIL tmo_data: got %h, need %h", ds, ed); else passed++;
    total++; if (cs !== 8'(mdl_cnt) || xa !== mdl_adr) $display("FAIL tmo_status: cnt=%0d adr=%h, need %0d %h", cs, xa, mdl_cnt, mdl_adr); else passed++;
    // Ack arriving in the last allowed cycle must still be a normal completion.
    run_txn(5'h05, 1'b0, 1'b0, 8'h00, TMO - 1, 8'hC3, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h05, TMO - 1, 8'hC3, 1'b0, ea, ee, ec, es, ed);
    total++; if (ga !== ea || ge !== ee || rc != ec || ds !== ed) $display("FAIL tmo_tie: ack=%b err=%b cyc=%0d dat=%h, need %b %b %0d %h", ga, ge, rc, ds, ea, ee, ec, ed); else passed++;
  endtask

  task automatic test_unmapped();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    run_txn(5'h1F, 1'b1, 1'b1, 8'h42, 0, 8'h00, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h1F, 0, 8'h00, 1'b0, ea, ee, ec, es, ed);
    total++; if (ga !== ea || ge !== ee || rc != ec) $display("FAIL unmap_resp: ack=%b err=%b cyc=%0d, need %b %b %0d", ga, ge, rc, ea, ee, ec); else passed++;
    total++; if (sc != 0 || bs !== 1'b0 || ds !== ed) $display("FAIL unmap_strobe: cycles=%0d bad=%b dat=%h, need 0 0 %h", sc, bs, ds, ed); else passed++;
    total++; if (xa !== mdl_adr || cs !== 8'(mdl_cnt)) $display("FAIL unmap_status: adr=%h cnt=%0d, need %h %0d", xa, cs, mdl_adr, mdl_cnt); else passed++;
  endtask

  task automatic test_abort();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    run_txn(5'h0A, 1'b0, 1'b0, 8'h00, -1, 8'h99, 2, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    total++; if (nr != 0 || sc != 2 || bs !== 1'b0) $display("FAIL abort: responses=%0d strobes=%0d bad=%b, need 0 2 0", nr, sc, bs); else passed++;
    total++; if (err_cnt !== 8'(mdl_cnt) || m_dat_o !== mdl_dat) $display("FAIL abort_state: cnt=%0d dat=%h, need %0d %h", err_cnt, m_dat_o, mdl_cnt, mdl_dat); else passed++;
    run_txn(5'h0C, 1'b0, 1'b1, 8'h00, 1, 8'h6E, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h0C, 1, 8'h6E, 1'b0, ea, ee, ec, es, ed);
    total++; if (ga !== ea || rc != ec || ds !== ed || sc != es) $display("FAIL after_abort: ack=%b cyc=%0d dat=%h stb=%0d, need %b %0d %h %0d", ga, rc, ds, sc, ea, ec, ed, es); else passed++;
  endtask

  task automatic test_clear();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    mdl_cnt = 0; mdl_adr = '0;
    total++; if (err_cnt !== 8'd0 || err_adr !== 5'd0) $display("FAIL clear: cnt=%0d adr=%h, need 0 00", err_cnt, err_adr); else passed++;
    run_txn(5'h1A, 1'b0, 1'b0, 8'h00, -1, 8'h00, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h1A, -1, 8'h00, 1'b0, ea, ee, ec, es, ed);
    run_txn(5'h1D, 1'b0, 1'b0, 8'h00, -1, 8'h00, -1, 1'b1, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
    predict(5'h1D, -1, 8'h00, 1'b1, ea, ee, ec, es, ed);
    total++; if (cs !== 8'(mdl_cnt) || xa !== mdl_adr) $display("FAIL clear_vs_err: cnt=%0d adr=%h, need %0d %h", cs, xa, mdl_cnt, mdl_adr); else passed++;
  endtask

  task automatic test_saturate();
    int rc, nr, sc, ec, es; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed; logic [4:0] xa;
    logic [4:0] a;
    for (int i = 0; i < 260; i++) begin
      a = 5'(24 + $urandom_range(0, 7));
      run_txn(a, 1'b0, 1'b0, 8'h00, -1, 8'h00, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
      predict(a, -1, 8'h00, 1'b0, ea, ee, ec, es, ed);
    end
    total++; if (err_cnt !== 8'(mdl_cnt) || err_adr !== mdl_adr) $display("FAIL saturate: cnt=%0d adr=%h, need %0d %h", err_cnt, err_adr, mdl_cnt, mdl_adr); else passed++;
  endtask

  task automatic test_random();
    int rc, nr, sc, ec, es, d; logic ga, ge, bs, bh, ea, ee; logic [7:0] ds, cs, ed, wd, rd; logic [4:0] xa, a;
    logic w, sl;
    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom); w = 1'($urandom); sl = 1'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      d = int'($urandom_range(0, 6)) - 1;
      run_txn(a, w, sl, wd, d, rd, -1, 1'b0, rc, nr, ga, ge, ds, sc, bs, bh, cs, xa);
      predict(a, d, rd, 1'b0, ea, ee, ec, es, ed);
      total++;
      if (ga !== ea || ge !== ee || rc != ec || nr != 1 || ds !== ed)
        $display("FAIL rand_resp[%0d] adr=%h dly=%0d: ack=%b err=%b cyc=%0d n=%0d dat=%h, need %b %b %0d 1 %h", i, a, d, ga, ge, rc, nr, ds, ea, ee, ec, ed);
      else passed++;
      total++;
      if (sc != es || bs !== 1'b0 || bh !== 1'b0 || cs !== 8'(mdl_cnt) || xa !== mdl_adr)
        $display("FAIL rand_side[%0d]: stb=%0d bad=%b shared=%b cnt=%0d adr=%h, need %0d 0 0 %0d %h", i, sc, bs, bh, cs, xa, es, mdl_cnt, mdl_adr);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [41:0] v;
    logic extra;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 1'b1; m_adr = 5'h09; m_dat = 8'hE7; s_ack = '0;
    @(negedge clk);
    total++; if (s_stb !== 3'b010) $display("FAIL midrst_pre: s_stb=%b, need 010", s_stb); else passed++;
    @(negedge clk);
    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    v = {m_ack, m_err, m_dat_o, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, err_cnt, err_adr};
    total++; if (v !== '0) $display("FAIL midrst_outputs: got %h, need 0", v); else passed++;
    rst_n = 1'b1;
    extra = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (m_ack !== 1'b0 || m_err !== 1'b0 || s_stb !== 3'b000) extra = 1'b1;
    end
    total++; if (extra !== 1'b0) $display("FAIL midrst_quiet: spurious activity=%b, need 0", extra); else passed++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_unmapped();
    test_abort();
    test_clear();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
